// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier / restoring divider (MULT/MULTU/DIV/DIVU)
//
// Computes one result bit per clock. A request is latched in IDLE. CALC then runs for exactly
// WIDTH cycles. FIX applies the result signs and writes hi/lo.
// Latency from the accepted start edge to the done cycle is WIDTH+2 clocks, for every op.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : op[0] selects signed (MULT/DIV) handling.
//   undefined : op[0] is ignored, every op is unsigned, and no negation logic is built.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   start        in   request, sampled only while idle
//   op[1:0]      in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a[W-1:0]     in   multiplicand / dividend
//   b[W-1:0]     in   multiplier / divisor
//   busy         out  high while CALC or FIX
//   done         out  one-cycle pulse, hi/lo valid from this cycle
//   hi[W-1:0]    out  product upper half / remainder
//   lo[W-1:0]    out  product lower half / quotient
//   div_by_zero  out  set with done for a divide by zero, cleared on the next accepted start

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic                 is_div_q,   is_div_d;
    logic [WIDTH-1:0]     opnd_q,     opnd_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q,      acc_d;       // {hi,lo} product or {rem,quo}
    logic                 dbz_pend_q, dbz_pend_d;  // current divide has b==0
    logic [CW-1:0]        cnt_q,      cnt_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 dbz_q,      dbz_d;
    logic [WIDTH-1:0]     hi_q,       hi_d;
    logic [WIDTH-1:0]     lo_q,       lo_d;

    // Per-cycle datapath terms
    logic [WIDTH:0]       mul_sum;     // W+1 bits keeps the carry of the upper-half add
    logic [WIDTH:0]       rem_sh;      // remainder after shift-in, can reach W+1 bits
    logic [WIDTH-1:0]     quo_sh;
    logic                 div_ok;      // trial subtraction has no borrow
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     opa_in;
    logic [WIDTH-1:0]     opb_in;

`ifdef MULDIV_SIGNED_EN
    logic                 neg_res_q,  neg_res_d;   // product / quotient must be negated
    logic                 neg_rem_q,  neg_rem_d;   // remainder follows the sign of a
    logic                 sign_a;
    logic                 sign_b;

    // Magnitudes are W-bit unsigned, so -0x80000000 is correctly 0x80000000
    always_comb begin
        sign_a = op[0] & a[WIDTH-1];
        sign_b = op[0] & b[WIDTH-1];
        opa_in = sign_a ? -a : a;
        opb_in = sign_b ? -b : b;
    end
`else
    logic                 unused_op0;

    assign unused_op0 = op[0];
    assign opa_in     = a;
    assign opb_in     = b;
`endif

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        quo_sh   = {acc_q[WIDTH-2:0], 1'b0};
        div_ok   = (rem_sh >= {1'b0, opnd_q});
        // When div_ok the difference is below the divisor, so W bits are exact
        div_diff = rem_sh[WIDTH-1:0] - opnd_q;
    end

    // Sign fix-up of the finished magnitude result
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
        prod_fix = acc_q;
        quo_fix  = acc_q[WIDTH-1:0];
        rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif
    end

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        dbz_pend_d = dbz_pend_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
`ifdef MULDIV_SIGNED_EN
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d   = op[1];
                    dbz_pend_d = op[1] & (b == '0);
                    dbz_d      = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = CW'(WIDTH - 1);
                    state_d    = S_CALC;
                    if (op[1]) begin
                        opnd_d = opb_in;
                        acc_d  = {{WIDTH{1'b0}}, opa_in};
                    end else begin
                        opnd_d = opa_in;
                        acc_d  = {{WIDTH{1'b0}}, opb_in};
                    end
`ifdef MULDIV_SIGNED_EN
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
`endif
                end
            end

            S_CALC: begin
                if (is_div_q) begin
                    // A zero divisor always passes the trial, giving quo=all ones and rem=|a|
                    if (div_ok) begin
                        acc_d = {div_diff, quo_sh | {{(WIDTH-1){1'b0}}, 1'b1}};
                    end else begin
                        acc_d = {rem_sh[WIDTH-1:0], quo_sh};
                    end
                end else begin
                    if (acc_q[0]) begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_FIX: begin
                if (is_div_q) begin
                    // The sign-corrected remainder of a zero divide is a itself
                    hi_d  = rem_fix;
                    lo_d  = dbz_pend_q ? {WIDTH{1'b1}} : quo_fix;
                    dbz_d = dbz_pend_q;
                end else begin
                    hi_d  = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d  = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_div_q   <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            dbz_pend_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            dbz_pend_q <= dbz_pend_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit

module tb_mul_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for done; lat counts edges from the accepting edge
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output logic busy_s, output logic dbz_s);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        busy_s = busy;
        dbz_s  = div_by_zero;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_multu();
        int lat; logic bs; logic ds;
        run_op(2'b00, 32'd6, 32'd16, lat, bs, ds);
        checks++; if (bs !== 1'b1) begin errors++; $display("FAIL multu_busy_rise got %b want 1", bs); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, LAT); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL multu_small_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'h60) begin errors++; $display("FAIL multu_small_lo got %h want 00000060", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_fall got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bs, ds);
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h1) begin errors++; $display("FAIL multu_max_lo got %h want 00000001", lo); end
    endtask

    task automatic test_mult();
        int lat; logic bs; logic ds;
        logic [W-1:0] e_hi1; logic [W-1:0] e_lo1; logic [W-1:0] e_hi2; logic [W-1:0] e_lo2;
`ifdef MULDIV_SIGNED_EN
        e_hi1 = 32'h0;         e_lo1 = 32'h1;
        e_hi2 = 32'hFFFF_FFFF; e_lo2 = 32'hFFFF_FFF1;
`else
        e_hi1 = 32'hFFFF_FFFE; e_lo1 = 32'h1;
        e_hi2 = 32'h4;         e_lo2 = 32'hFFFF_FFF1;
`endif
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bs, ds);
        checks++; if (hi !== e_hi1) begin errors++; $display("FAIL mult_m1_hi got %h want %h", hi, e_hi1); end
        checks++; if (lo !== e_lo1) begin errors++; $display("FAIL mult_m1_lo got %h want %h", lo, e_lo1); end
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bs, ds);
        checks++; if (hi !== e_hi2) begin errors++; $display("FAIL mult_neg_hi got %h want %h", hi, e_hi2); end
        checks++; if (lo !== e_lo2) begin errors++; $display("FAIL mult_neg_lo got %h want %h", lo, e_lo2); end
    endtask

    task automatic test_div();
        int lat; logic bs; logic ds;
        logic [W-1:0] e_hi1; logic [W-1:0] e_lo1; logic [W-1:0] e_hi2; logic [W-1:0] e_lo2;
`ifdef MULDIV_SIGNED_EN
        e_lo1 = 32'hFFFF_FFFD; e_hi1 = 32'hFFFF_FFFF;
        e_lo2 = 32'h8000_0000; e_hi2 = 32'h0;
`else
        e_lo1 = 32'h7FFF_FFFC; e_hi1 = 32'h1;
        e_lo2 = 32'h0;         e_hi2 = 32'h8000_0000;
`endif
        run_op(2'b10, 32'd30, 32'd6, lat, bs, ds);
        checks++; if (lat != LAT) begin errors++; $display("FAIL divu_latency got %0d want %0d", lat, LAT); end
        checks++; if (lo !== 32'd5) begin errors++; $display("FAIL divu_lo got %h want 00000005", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divu_hi got %h want 00000000", hi); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bs, ds);
        checks++; if (lo !== e_lo1) begin errors++; $display("FAIL div_neg_lo got %h want %h", lo, e_lo1); end
        checks++; if (hi !== e_hi1) begin errors++; $display("FAIL div_neg_hi got %h want %h", hi, e_hi1); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bs, ds);
        checks++; if (lo !== e_lo2) begin errors++; $display("FAIL div_ovf_lo got %h want %h", lo, e_lo2); end
        checks++; if (hi !== e_hi2) begin errors++; $display("FAIL div_ovf_hi got %h want %h", hi, e_hi2); end
    endtask

    task automatic test_div_by_zero();
        int lat; logic bs; logic ds;
        run_op(2'b10, 32'h1234, 32'h0, lat, bs, ds);
        checks++; if (lat != LAT) begin errors++; $display("FAIL dbz_latency got %0d want %0d", lat, LAT); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL dbz_hi got %h want 00001234", hi); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold got %b want 1", div_by_zero); end
        run_op(2'b10, 32'd30, 32'd6, lat, bs, ds);
        checks++; if (ds !== 1'b0) begin errors++; $display("FAIL dbz_clear got %b want 0", ds); end
        checks++; if (lo !== 32'd5) begin errors++; $display("FAIL dbz_next_lo got %h want 00000005", lo); end
        run_op(2'b11, 32'hFFFF_FFFB, 32'h0, lat, bs, ds);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdbz_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL sdbz_hi got %h want fffffffb", hi); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL sdbz_flag got %b want 1", div_by_zero); end
    endtask

    task automatic test_ignored_start();
        int ndone = 0; int done_at = 0;
        logic [W-1:0] hs = '0; logic [W-1:0] ls = '0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 32'h0001_2345; b = 32'h0001_0000;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= W + 8; c++) begin
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin done_at = c; hs = hi; ls = lo; end
            end
            if (c == 5) begin start = 1'b1; op = 2'b10; a = 32'd7; b = 32'd7; end
            else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
        checks++; if (done_at != LAT) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", done_at, LAT); end
        checks++; if (hs !== 32'h1) begin errors++; $display("FAIL busy_start_hi got %h want 00000001", hs); end
        checks++; if (ls !== 32'h2345_0000) begin errors++; $display("FAIL busy_start_lo got %h want 23450000", ls); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic bs; logic ds; int ndone = 0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL midrst_hi got %h want 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL midrst_lo got %h want 0", lo); end
        for (int c = 0; c < W + 6; c++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        run_op(2'b10, 32'd100, 32'd7, lat, bs, ds);
        checks++; if (lat != LAT) begin errors++; $display("FAIL midrst_next_latency got %0d want %0d", lat, LAT); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL midrst_next_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL midrst_next_hi got %h want 00000002", hi); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_ignored_start();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
